comp_sequencer: RTL
===================

Name: comp_sequencer

Overview:
Sequencer for the DPLL PI compensation pipeline.
- Runs the compensator at a programmable loop-sample rate.
- Captures phase-detector error samples.
- Applies gain/limit changes atomically, only between compensation runs.
- Presents each new compensator output with a one-cycle valid strobe.
- Sits between the phase detector / register file and the compensation block; drives its err, gain, dlim, enable and process inputs.

Parameters:
WIDTH, 17, compensator output width
WIDTH_ERR, 22, error and dlim width
fsze, 6, gain shift-field width
DIV_W, 16, sample-period counter width
PIPE_LAT, 9, cycles from process rising edge to valid compensator output

Ports:
sys_clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
loop_en  in  1  loop run enable
div  in  DIV_W  sample period in sys_clk cycles
err_in  in  WIDTH_ERR  signed phase error
err_stb  in  1  err_in valid strobe
cfg_ki/cfg_kp/cfg_k0  in  fsze  requested gain shifts
cfg_dlim  in  WIDTH_ERR  requested integrator limit
cfg_wr  in  1  config write strobe
cfg_ack  out  1  pulse: pending config applied
comp_err  out  WIDTH_ERR  error to compensator
comp_ki/comp_kp/comp_k0  out  fsze  active gains
comp_dlim  out  WIDTH_ERR  active limit
comp_enable  out  1  compensator enable
comp_process  out  1  compensator start
comp_uk  in  WIDTH  compensator output
uk_out  out  WIDTH  latched control word
uk_valid  out  1  one-cycle pulse: new uk_out
err_miss  out  1  pulse: tick with no fresh error

Behaviour:
- One clock, sys_clk. Reset is synchronous, active-low (rst_n).
- Values after reset: all outputs 0; state IDLE; no pending config.
  - comp_ki=0, comp_kp=0, comp_k0=0.
  - comp_dlim=0, so the integrator is clamped to 0 until the first config is applied.

Tick counter:
- Effective period P = max(div, PIPE_LAT+3).
- Counts down from P-1 to 0, reloads, and raises tick at 0.
- Held at P-1 while loop_en=0.

Error capture:
- err_stb latches err_in into err_hold and sets fresh.
- fresh clears at LAUNCH.
- If err_stb coincides with LAUNCH, the new sample is kept and fresh stays set.

Config:
- cfg_wr stores the cfg_* fields in a pending set and sets pend.
- A later cfg_wr before apply overwrites the pending set. Last write wins; only one ack is produced.
- Pending values are copied to the comp_* gain/dlim outputs only in the LAUNCH cycle.
- cfg_ack pulses in the cycle after the copy.
- cfg_wr in the LAUNCH cycle itself is deferred to the next launch.

FSM:
- IDLE
  - comp_enable=0.
  - Leaves to WAIT when loop_en=1.
- WAIT
  - comp_enable=1.
  - On tick with fresh=1: go to LAUNCH.
  - On tick with fresh=0: pulse err_miss and stay in WAIT.
- LAUNCH (1 cycle)
  - comp_err <= err_hold.
  - Apply pending config.
  - comp_process=1 for this one cycle only.
  - Next state: BUSY.
- BUSY
  - Counts PIPE_LAT cycles.
  - comp_err, gains and dlim are held constant throughout.
- LATCH (1 cycle)
  - uk_out <= comp_uk.
  - uk_valid=1.
  - Next state: WAIT.

Timing and control rules:
- Latency: uk_valid asserts PIPE_LAT+1 cycles after the comp_process cycle.
- Ticks cannot occur in LAUNCH/BUSY/LATCH, because of the P clamp.
- loop_en=0 in any state:
  - Next cycle: state IDLE, comp_enable=0, comp_process=0.
  - uk_out cleared to 0, uk_valid=0.
  - Any in-flight result is discarded.
  - Pending config and err_hold are retained.
- rst_n=0 mid-operation returns everything to reset values on the next edge.

Optional Feature:
COMP_SEQ_STATUS_EN
- Defined: adds output stat_miss [7:0] and input stat_clr [1].
  - stat_miss counts err_miss pulses and saturates at 255.
  - stat_clr=1 clears it; clear wins over a simultaneous increment.
  - Reset value 0.
- Undefined: these ports and logic are absent; err_miss pulses still exist.

Decomposition:
- Package comp_seq_pkg:
  - FSM state enum: IDLE, WAIT, LAUNCH, BUSY, LATCH.
  - PIPE_LAT default.
  - Minimum-period constant PIPE_LAT+3.
  - Config record type {ki, kp, k0, dlim}.
- One natural sub-module: comp_tick_gen, the period clamp, down-counter and tick output.

Test Plan:
1. Reset, then loop_en=1, div=20, err_stb every 20 cycles with err=+1000 → comp_process pulse once per 20 cycles; uk_valid exactly 10 cycles after each comp_process; uk_out equals comp_uk.
2. div=4 → effective period 12 cycles between comp_process pulses; no uk_valid is ever lost.
3. cfg_wr kp=3, then cfg_wr kp=5 before the next launch → comp_kp changes only in the LAUNCH cycle, to 5; exactly one cfg_ack; comp_* stable through BUSY.
4. err_stb withheld for one period → err_miss pulse at that tick, no comp_process; normal launch at the next tick after err_stb.
5. loop_en dropped 3 cycles into BUSY → next cycle: comp_enable=0, uk_out=0, no uk_valid. Re-enable → resumes with the retained err_hold.
6. rst_n=0 for 1 cycle during BUSY → all outputs 0 next cycle. With COMP_SEQ_STATUS_EN: 300 misses → stat_miss=255; stat_clr → 0.

Source files
------------

// File: rtl/comp_seq_pkg.sv
// Shared constants, FSM state and configuration record for the DPLL compensation sequencer.
package comp_seq_pkg;

  localparam int unsigned WIDTH      = 17;
  localparam int unsigned WIDTH_ERR  = 22;
  localparam int unsigned FSZE       = 6;
  localparam int unsigned DIV_W      = 16;
  localparam int unsigned PIPE_LAT   = 9;
  // Shortest period that still fits LAUNCH + BUSY + LATCH + one WAIT cycle.
  localparam int unsigned MIN_PERIOD = PIPE_LAT + 3;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StLaunch,
    StBusy,
    StLatch
  } seq_state_e;

  typedef struct packed {
    logic [FSZE-1:0]      ki;
    logic [FSZE-1:0]      kp;
    logic [FSZE-1:0]      k0;
    logic [WIDTH_ERR-1:0] dlim;
  } cfg_t;

endpackage

// File: rtl/comp_sequencer_if.sv
// Bus between the sequencer (master) and phase detector / register file / compensator (slave).
// Optional status signals stat_clr/stat_miss exist only when COMP_SEQ_STATUS_EN is defined.
interface comp_sequencer_if;
  import comp_seq_pkg::*;

  logic                        loop_en;
  logic [DIV_W-1:0]            div;
  logic signed [WIDTH_ERR-1:0] err_in;
  logic                        err_stb;
  logic [FSZE-1:0]             cfg_ki;
  logic [FSZE-1:0]             cfg_kp;
  logic [FSZE-1:0]             cfg_k0;
  logic [WIDTH_ERR-1:0]        cfg_dlim;
  logic                        cfg_wr;
  logic                        cfg_ack;
  logic signed [WIDTH_ERR-1:0] comp_err;
  logic [FSZE-1:0]             comp_ki;
  logic [FSZE-1:0]             comp_kp;
  logic [FSZE-1:0]             comp_k0;
  logic [WIDTH_ERR-1:0]        comp_dlim;
  logic                        comp_enable;
  logic                        comp_process;
  logic [WIDTH-1:0]            comp_uk;
  logic [WIDTH-1:0]            uk_out;
  logic                        uk_valid;
  logic                        err_miss;
`ifdef COMP_SEQ_STATUS_EN
  logic                        stat_clr;
  logic [7:0]                  stat_miss;

  modport master (
    input  loop_en, div, err_in, err_stb, cfg_ki, cfg_kp, cfg_k0, cfg_dlim, cfg_wr, comp_uk,
           stat_clr,
    output cfg_ack, comp_err, comp_ki, comp_kp, comp_k0, comp_dlim, comp_enable, comp_process,
           uk_out, uk_valid, err_miss, stat_miss
  );
  modport slave (
    output loop_en, div, err_in, err_stb, cfg_ki, cfg_kp, cfg_k0, cfg_dlim, cfg_wr, comp_uk,
           stat_clr,
    input  cfg_ack, comp_err, comp_ki, comp_kp, comp_k0, comp_dlim, comp_enable, comp_process,
           uk_out, uk_valid, err_miss, stat_miss
  );
`else
  modport master (
    input  loop_en, div, err_in, err_stb, cfg_ki, cfg_kp, cfg_k0, cfg_dlim, cfg_wr, comp_uk,
    output cfg_ack, comp_err, comp_ki, comp_kp, comp_k0, comp_dlim, comp_enable, comp_process,
           uk_out, uk_valid, err_miss
  );
  modport slave (
    output loop_en, div, err_in, err_stb, cfg_ki, cfg_kp, cfg_k0, cfg_dlim, cfg_wr, comp_uk,
    input  cfg_ack, comp_err, comp_ki, comp_kp, comp_k0, comp_dlim, comp_enable, comp_process,
           uk_out, uk_valid, err_miss
  );
`endif

endinterface

// File: rtl/comp_tick_gen.sv
// Loop-sample tick generator: clamped period, down-counter, tick when the count reaches 0.
module comp_tick_gen
  import comp_seq_pkg::*;
(
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  localparam logic [DIV_W-1:0] MinP = DIV_W'(MIN_PERIOD);

  logic [DIV_W-1:0] w_period;
  logic [DIV_W-1:0] w_reload;
  logic [DIV_W-1:0] r_cnt;

  assign w_period = (i_div < MinP) ? MinP : i_div;
  assign w_reload = w_period - DIV_W'(1);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || (r_cnt == '0)) begin
      r_cnt <= w_reload;
    end else begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/comp_sequencer.sv
// DPLL PI compensation sequencer: error capture, atomic config apply, launch and result latch.
// Define COMP_SEQ_STATUS_EN to add the saturating err_miss counter (stat_miss / stat_clr).
module comp_sequencer
  import comp_seq_pkg::*;
(
  input logic        sys_clk,
  input logic        rst_n,
  comp_sequencer_if.master bus
);

  localparam int unsigned BUSY_W = $clog2(PIPE_LAT + 1);

  seq_state_e                  r_state;
  logic [BUSY_W-1:0]           r_busy_cnt;
  logic signed [WIDTH_ERR-1:0] r_err_hold;
  logic                        r_fresh;
  cfg_t                        r_pend_cfg;
  logic                        r_pend;
  cfg_t                        r_act_cfg;
  logic                        r_ack_arm;
  logic signed [WIDTH_ERR-1:0] r_comp_err;
  logic                        r_enable;
  logic                        r_process;
  logic                        r_cfg_ack;
  logic                        r_uk_valid;
  logic                        r_err_miss;
  logic [WIDTH-1:0]            r_uk;
  logic                        w_tick;
  logic                        w_launch;

  comp_tick_gen u_tick (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .i_en    (bus.loop_en),
    .i_div   (bus.div),
    .o_tick  (w_tick)
  );

  assign w_launch = (r_state == StWait) && bus.loop_en && w_tick && r_fresh;

  // A strobe coinciding with launch wins, so the new sample stays fresh.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_err_hold <= '0;
      r_fresh    <= 1'b0;
    end else if (bus.err_stb) begin
      r_err_hold <= bus.err_in;
      r_fresh    <= 1'b1;
    end else if (w_launch) begin
      r_fresh    <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_pend_cfg <= '0;
      r_pend     <= 1'b0;
    end else if (bus.cfg_wr) begin
      r_pend_cfg <= '{ki: bus.cfg_ki, kp: bus.cfg_kp, k0: bus.cfg_k0, dlim: bus.cfg_dlim};
      r_pend     <= 1'b1;
    end else if (w_launch) begin
      r_pend     <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_busy_cnt <= '0;
      r_act_cfg  <= '0;
      r_ack_arm  <= 1'b0;
      r_comp_err <= '0;
      r_enable   <= 1'b0;
      r_process  <= 1'b0;
      r_cfg_ack  <= 1'b0;
      r_uk_valid <= 1'b0;
      r_err_miss <= 1'b0;
      r_uk       <= '0;
    end else begin
      r_process  <= 1'b0;
      r_cfg_ack  <= 1'b0;
      r_uk_valid <= 1'b0;
      r_err_miss <= 1'b0;
      if (!bus.loop_en) begin
        r_state  <= StIdle;
        r_enable <= 1'b0;
        r_uk     <= '0;
      end else begin
        case (r_state)
          StIdle: begin
            r_state  <= StWait;
            r_enable <= 1'b1;
          end
          StWait: begin
            if (w_tick && r_fresh) begin
              r_state    <= StLaunch;
              r_process  <= 1'b1;
              r_comp_err <= r_err_hold;
              r_ack_arm  <= r_pend;
              if (r_pend) r_act_cfg <= r_pend_cfg;
            end else if (w_tick) begin
              r_err_miss <= 1'b1;
            end
          end
          StLaunch: begin
            r_state    <= StBusy;
            r_busy_cnt <= BUSY_W'(PIPE_LAT - 1);
            r_cfg_ack  <= r_ack_arm;
          end
          StBusy: begin
            if (r_busy_cnt == '0) begin
              r_state    <= StLatch;
              r_uk       <= bus.comp_uk;
              r_uk_valid <= 1'b1;
            end else begin
              r_busy_cnt <= r_busy_cnt - BUSY_W'(1);
            end
          end
          StLatch: r_state <= StWait;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign bus.cfg_ack      = r_cfg_ack;
  assign bus.comp_err     = r_comp_err;
  assign bus.comp_ki      = r_act_cfg.ki;
  assign bus.comp_kp      = r_act_cfg.kp;
  assign bus.comp_k0      = r_act_cfg.k0;
  assign bus.comp_dlim    = r_act_cfg.dlim;
  assign bus.comp_enable  = r_enable;
  assign bus.comp_process = r_process;
  assign bus.uk_out       = r_uk;
  assign bus.uk_valid     = r_uk_valid;
  assign bus.err_miss     = r_err_miss;

`ifdef COMP_SEQ_STATUS_EN
  logic [7:0] r_stat_miss;

  always_ff @(posedge sys_clk) begin
    if (!rst_n || bus.stat_clr) begin
      r_stat_miss <= '0;
    end else if (r_err_miss && (r_stat_miss != 8'hFF)) begin
      r_stat_miss <= r_stat_miss + 8'd1;
    end
  end

  assign bus.stat_miss = r_stat_miss;
`endif

endmodule
